// File: rtl/bit_count_pkg.sv
// Shared types for the bit counting engine: controller states and count modes.
package bit_count_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  typedef enum logic {
    MODE_ONES  = 1'b0,
    MODE_ZEROS = 1'b1
  } mode_t;

endpackage

// File: rtl/step_popcount.sv
// Combinational popcount of one STEP-bit chunk of the shift register.
module step_popcount #(
  parameter int STEP = 1,
  localparam int PW  = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] bits,
  output logic [PW-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < STEP; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/bit_count_engine.sv
// Start/done bit counter, STEP bits per cycle; define
// BIT_COUNT_ENGINE_EARLY_EXIT_EN to stop once the remaining bits are zero.
module bit_count_engine
  import bit_count_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int RW   = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [WIDTH-1:0] num,
  input  logic          mode,
  output logic [RW-1:0] result,
  output logic          done,
  output logic          busy
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int PW     = $clog2(STEP + 1);

  generate
    if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad
      $error("bit_count_engine: WIDTH must be >=1 and a multiple of STEP");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [PW-1:0]    pc;
  logic             last;
  mode_t            mode_q;

  assign mode_q = mode_t'(mode);
  assign busy   = (state == S_COUNT);
  assign done   = (state == S_DONE);

  step_popcount #(.STEP(STEP)) u_pop (
    .bits  (a[STEP-1:0]),
    .count (pc)
  );

`ifdef BIT_COUNT_ENGINE_EARLY_EXIT_EN
  always_comb begin
    last = ((a >> STEP) == '0);
  end
`else
  localparam int CW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_COUNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    last = (cnt == CW'(NSTEPS - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start) state <= S_COUNT;
        S_COUNT: if (last) state <= S_DONE;
        S_DONE:  if (!start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a      <= '0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a      <= num ^ {WIDTH{mode_q == MODE_ZEROS}};
            result <= '0;
          end
        end
        S_COUNT: begin
          a      <= a >> STEP;
          result <= result + RW'(pc);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_count_engine.sv
// Self-checking bench: directed plus random operations on an 8x1 and a
// 16x4 instance, compared against a bit-level reference model.
module tb_bit_count_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start16;
  logic        mode8, mode16;
  logic [7:0]  num8;
  logic [15:0] num16;
  logic [3:0]  res8;
  logic [4:0]  res16;
  logic        done8, busy8, done16, busy16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_count_engine #(.WIDTH(8), .STEP(1)) d8 (
    .clk    (clk),
    .reset  (reset),
    .start  (start8),
    .num    (num8),
    .mode   (mode8),
    .result (res8),
    .done   (done8),
    .busy   (busy8)
  );

  bit_count_engine #(.WIDTH(16), .STEP(4)) d16 (
    .clk    (clk),
    .reset  (reset),
    .start  (start16),
    .num    (num16),
    .mode   (mode16),
    .result (res16),
    .done   (done16),
    .busy   (busy16)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bits that differ from mode are the ones being counted.
  function automatic int model_count(int w, logic [15:0] n, logic m);
    int c = 0;
    for (int i = 0; i < w; i++) if (n[i] != m) c++;
    return c;
  endfunction

  function automatic int model_lat(int w, int s, logic [15:0] n, logic m);
    int hi = 0;
    for (int c = 0; c < w / s; c++)
      for (int b = 0; b < s; b++)
        if (n[c*s+b] != m) hi = c;
`ifdef BIT_COUNT_ENGINE_EARLY_EXIT_EN
    return hi + 1;
`else
    return (hi >= 0) ? w / s : 0;
`endif
  endfunction

  function automatic int o_res(bit wide);
    return wide ? int'(res16) : int'(res8);
  endfunction

  function automatic int o_done(bit wide);
    return wide ? int'(done16) : int'(done8);
  endfunction

  function automatic int o_busy(bit wide);
    return wide ? int'(busy16) : int'(busy8);
  endfunction

  task automatic set_start(bit wide, logic v);
    if (wide) start16 = v;
    else start8 = v;
  endtask

  // Called at a negedge; returns at a negedge with start low and DUT idle.
  task automatic run_op(input bit wide, input logic [15:0] n,
                        input logic m, input bit toggle, input int hold);
    int w   = wide ? 16 : 8;
    int s   = wide ? 4 : 1;
    int exp = model_count(w, n, m);
    int lat = model_lat(w, s, n, m);
    int k   = 0;
    if (wide) begin
      num16 = n;
      mode16 = m;
    end else begin
      num8 = n[7:0];
      mode8 = m;
    end
    set_start(wide, 1'b1);
    @(negedge clk);
    chk("busy_after_e0", o_busy(wide), 1);
    chk("done_after_e0", o_done(wide), 0);
    while (o_done(wide) == 0 && k < 100) begin
      if (toggle) begin
        num16 = 16'($urandom);
        num8  = 8'($urandom);
        mode16 = 1'($urandom);
        mode8  = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    chk("latency", k, lat);
    chk("result", o_res(wide), exp);
    chk("busy_in_done", o_busy(wide), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("done_held", o_done(wide), 1);
      chk("result_held", o_res(wide), exp);
    end
    set_start(wide, 1'b0);
    @(negedge clk);
    chk("done_fall", o_done(wide), 0);
    chk("idle_result_kept", o_res(wide), exp);
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0;
    start16 = 1'b0;
    mode8 = 1'b0;
    mode16 = 1'b0;
    num8 = '0;
    num16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_res8", int'(res8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_res16", int'(res16), 0);
    chk("rst_done16", int'(done16), 0);
    chk("rst_busy16", int'(busy16), 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 16'h0081, 1'b0, 1'b0, 3);
    run_op(1'b0, 16'h0001, 1'b0, 1'b0, 0);
    run_op(1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(1'b0, 16'h00FF, 1'b0, 1'b0, 1);
    run_op(1'b0, 16'h00AA, 1'b1, 1'b1, 0);
    run_op(1'b1, 16'hF0F0, 1'b0, 1'b1, 2);
    run_op(1'b1, 16'h0000, 1'b0, 1'b0, 0);
    run_op(1'b1, 16'h0000, 1'b1, 1'b0, 0);

    // Reset in the middle of a count.
    num8 = 8'hFF;
    mode8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("busy_before_reset", int'(busy8), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_res", int'(res8), 0);
    chk("midrst_done", int'(done8), 0);
    chk("midrst_busy", int'(busy8), 0);
    reset = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    run_op(1'b0, 16'h000F, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(1'b0, 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
      run_op(1'b1, 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
